// File: rtl/pc_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg
// Shared types and constants for the fetch-stage program counter.
//   redirect_src_t : which fresh redirect (if any) is requesting the PC
//   PC_STEP        : sequential fetch increment in bytes
//   pend_t         : one-entry buffer for a redirect seen while stalled
//   misaligned()   : true when an address is not word aligned
// ---------------------------------------------------------------------------
package pc_pkg;

  localparam int PC_WIDTH = 32;
  localparam int PC_STEP  = 4;

  typedef enum logic [1:0] {
    RD_NONE,
    RD_BRANCH,
    RD_TRAP
  } redirect_src_t;

  typedef struct packed {
    logic                valid;
    logic [PC_WIDTH-1:0] tgt;
  } pend_t;

  function automatic logic misaligned(input logic [1:0] lsbs);
    return lsbs != 2'b00;
  endfunction

endpackage

// File: rtl/pc_btb.sv
// ---------------------------------------------------------------------------
// pc_btb
// Direct-mapped branch target buffer used for next-PC prediction.
// Only instantiated when PC_BTB_EN is defined.
// Ports:
//   clk, rst     : clock, synchronous active-high reset (clears valid bits)
//   lookup_pc    : PC being fetched
//   hit          : lookup_pc has a valid entry with matching tag
//   pred_target  : stored target for lookup_pc
//   upd_en       : write an entry this edge
//   upd_pc       : PC of the redirecting instruction (index + tag source)
//   upd_target   : word-aligned target to store
// ---------------------------------------------------------------------------
module pc_btb #(
  parameter int WIDTH   = 32,
  parameter int ENTRIES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] lookup_pc,
  output logic             hit,
  output logic [WIDTH-1:0] pred_target,
  input  logic             upd_en,
  input  logic [WIDTH-1:0] upd_pc,
  input  logic [WIDTH-1:0] upd_target
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = WIDTH - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [WIDTH-1:0]   tgt_q [ENTRIES];

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic [3:0]       unused_lsbs;

  // Byte-offset bits never select an entry; instructions are word aligned.
  assign lk_idx      = lookup_pc[IDX_W+1:2];
  assign lk_tag      = lookup_pc[WIDTH-1:IDX_W+2];
  assign upd_idx     = upd_pc[IDX_W+1:2];
  assign upd_tag     = upd_pc[WIDTH-1:IDX_W+2];
  assign unused_lsbs = {lookup_pc[1:0], upd_pc[1:0]};

  assign hit         = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_target = tgt_q[lk_idx];

  // Valid bits are the only state that needs reset; a write simply
  // claims its index, evicting whatever branch lived there before.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (upd_en) begin
      valid_q[upd_idx] <= 1'b1;
    end
  end

  // Tag/target storage; held off during reset so reset dominates updates.
  always_ff @(posedge clk) begin
    if (!rst && upd_en) begin
      tag_q[upd_idx] <= upd_tag;
      tgt_q[upd_idx] <= upd_target;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
// Fetch-stage program counter with stall, redirect (branch / trap), a
// one-entry pending-redirect buffer for redirects seen during a stall,
// misalignment flagging and an optional BTB predictor.
// Configuration macro: PC_BTB_EN (defined = BTB present, undefined = no BTB,
// pred_taken tied low, branch_pc ignored).
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   en            : 1 = advance, 0 = stall (PC held)
//   PCsrc         : execute-stage redirect, target PC_Target
//   branch_pc     : PC of redirecting instruction (BTB update)
//   trap_req      : trap redirect to trap_vec, highest priority
//   PC_out        : current fetch PC
//   PC_Plus4      : PC_out + 4, wrapping
//   flush         : one-cycle pulse when a redirect was applied
//   misalign_err  : one-cycle pulse when the applied target was misaligned
//   pred_taken    : BTB hit for PC_out
// ---------------------------------------------------------------------------
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH       = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VEC   = '0,
  parameter int               BTB_ENTRIES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             PCsrc,
  input  logic [WIDTH-1:0] PC_Target,
  input  logic [WIDTH-1:0] branch_pc,
  input  logic             trap_req,
  input  logic [WIDTH-1:0] trap_vec,
  output logic [WIDTH-1:0] PC_out,
  output logic [WIDTH-1:0] PC_Plus4,
  output logic             flush,
  output logic             misalign_err,
  output logic             pred_taken
);

  // The pending buffer type is sized by the package width.
  if (WIDTH != PC_WIDTH) begin : g_width_check
    $error("pc_fetch_unit: WIDTH must equal pc_pkg::PC_WIDTH");
  end

  localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(3));

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] fresh_tgt;
  logic [WIDTH-1:0] redirect_tgt;
  logic [WIDTH-1:0] btb_target;
  logic             apply_redirect;
  logic             btb_hit;
  pend_t            pend_q;
  redirect_src_t    fresh_src;

  assign PC_out   = pc_q;
  assign PC_Plus4 = pc_q + WIDTH'(PC_STEP);

  // Fresh redirect arbitration: a trap always beats a branch.
  always_comb begin
    fresh_src = RD_NONE;
    fresh_tgt = PC_Target;
    if (trap_req) begin
      fresh_src = RD_TRAP;
      fresh_tgt = trap_vec;
    end else if (PCsrc) begin
      fresh_src = RD_BRANCH;
    end
  end

  // Next-PC selection: fresh redirect > pending > BTB > sequential.
  // Alignment is forced only on redirect targets; the BTB already
  // stores aligned targets and sequential fetch stays aligned.
  always_comb begin
    redirect_tgt   = (fresh_src != RD_NONE) ? fresh_tgt : pend_q.tgt;
    apply_redirect = en && ((fresh_src != RD_NONE) || pend_q.valid);
    pc_next        = PC_Plus4;
    if (apply_redirect) begin
      pc_next = redirect_tgt & ALIGN_MASK;
    end else if (btb_hit) begin
      pc_next = btb_target;
    end
  end

  // PC, pending buffer and status pulses. While stalled, the latest
  // redirect is parked in the pending buffer; any advancing cycle either
  // consumes it or supersedes it with a fresh redirect, so it always clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_VEC;
      pend_q       <= '0;
      flush        <= 1'b0;
      misalign_err <= 1'b0;
    end else if (en) begin
      pc_q         <= pc_next;
      pend_q.valid <= 1'b0;
      flush        <= apply_redirect;
      misalign_err <= apply_redirect && misaligned(redirect_tgt[1:0]);
    end else begin
      flush        <= 1'b0;
      misalign_err <= 1'b0;
      if (fresh_src != RD_NONE) begin
        pend_q.valid <= 1'b1;
        pend_q.tgt   <= fresh_tgt;
      end
    end
  end

`ifdef PC_BTB_EN
  pc_btb #(
    .WIDTH   (WIDTH),
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk         (clk),
    .rst         (rst),
    .lookup_pc   (pc_q),
    .hit         (btb_hit),
    .pred_target (btb_target),
    .upd_en      (PCsrc),
    .upd_pc      (branch_pc),
    .upd_target  (PC_Target & ALIGN_MASK)
  );

  assign pred_taken = btb_hit;
`else
  logic unused_branch_pc;

  assign btb_hit          = 1'b0;
  assign btb_target       = '0;
  assign pred_taken       = 1'b0;
  assign unused_branch_pc = ^branch_pc;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_unit
// Scoreboard bench for pc_fetch_unit (RESET_VEC = 0x100). Each directed
// vector pushes the hand-computed state expected after the next rising
// edge; an independent monitor pops and compares one entry per cycle.
// Honours PC_BTB_EN for the prediction expectations.
// ---------------------------------------------------------------------------
module tb_pc_fetch_unit;

`ifdef PC_BTB_EN
  localparam bit BTB_ON = 1'b1;
`else
  localparam bit BTB_ON = 1'b0;
`endif

  localparam logic [31:0] BPC_IDLE = 32'hF000_0020;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        PCsrc;
  logic [31:0] PC_Target;
  logic [31:0] branch_pc;
  logic        trap_req;
  logic [31:0] trap_vec;
  logic [31:0] PC_out;
  logic [31:0] PC_Plus4;
  logic        flush;
  logic        misalign_err;
  logic        pred_taken;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        flush;
    logic        mis;
    logic        pred;
  } exp_t;

  exp_t sb_queue[$];
  int   vectors_applied = 0;
  int   miscompares     = 0;

  pc_fetch_unit #(
    .WIDTH       (32),
    .RESET_VEC   (32'h0000_0100),
    .BTB_ENTRIES (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .PCsrc        (PCsrc),
    .PC_Target    (PC_Target),
    .branch_pc    (branch_pc),
    .trap_req     (trap_req),
    .trap_vec     (trap_vec),
    .PC_out       (PC_out),
    .PC_Plus4     (PC_Plus4),
    .flush        (flush),
    .misalign_err (misalign_err),
    .pred_taken   (pred_taken)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  // Drive one cycle of inputs at the falling edge and queue the state
  // expected after the following rising edge.
  task automatic applyStimulus(input string name, input logic r, input logic e,
                               input logic br, input logic [31:0] tgt,
                               input logic tr, input logic [31:0] tv,
                               input logic [31:0] exp_pc, input logic exp_flush,
                               input logic exp_mis, input logic exp_pred);
    exp_t item;
    @(negedge clk);
    rst       = r;
    en        = e;
    PCsrc     = br;
    PC_Target = tgt;
    trap_req  = tr;
    trap_vec  = tv;
    item.name  = name;
    item.pc    = exp_pc;
    item.flush = exp_flush;
    item.mis   = exp_mis;
    item.pred  = exp_pred;
    sb_queue.push_back(item);
  endtask

  // Compare the DUT outputs against one scoreboard entry.
  task automatic checkOutput(input exp_t item);
    logic [31:0] exp_plus4;
    exp_plus4 = item.pc + 32'd4;
    vectors_applied++;
    if (PC_out !== item.pc || PC_Plus4 !== exp_plus4 || flush !== item.flush ||
        misalign_err !== item.mis || pred_taken !== item.pred) begin
      miscompares++;
      $display("[TB] FAIL %s: got pc=%h plus4=%h flush=%b mis=%b pred=%b, want pc=%h plus4=%h flush=%b mis=%b pred=%b",
               item.name, PC_out, PC_Plus4, flush, misalign_err, pred_taken,
               item.pc, exp_plus4, item.flush, item.mis, item.pred);
    end
  endtask

  // Monitor: the DUT presents a new state every cycle; sample just after
  // the rising edge and pop one expectation whenever one is outstanding.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_queue.size() != 0) checkOutput(sb_queue.pop_front());
    end
  end

  // Directed stimulus.
  initial begin
    rst       = 1'b1;
    en        = 1'b0;
    PCsrc     = 1'b0;
    PC_Target = '0;
    trap_req  = 1'b0;
    trap_vec  = '0;
    branch_pc = BPC_IDLE;

    // Reset and sequential fetch
    applyStimulus("reset0",   1, 0, 0, 0, 0, 0, 32'h100, 0, 0, 0);
    applyStimulus("reset1",   1, 0, 0, 0, 0, 0, 32'h100, 0, 0, 0);
    applyStimulus("seq104",   0, 1, 0, 0, 0, 0, 32'h104, 0, 0, 0);
    applyStimulus("seq108",   0, 1, 0, 0, 0, 0, 32'h108, 0, 0, 0);
    applyStimulus("seq10C",   0, 1, 0, 0, 0, 0, 32'h10C, 0, 0, 0);

    // Branch redirect, and trap beating a simultaneous branch
    applyStimulus("br200",    0, 1, 1, 32'h200, 0, 0, 32'h200, 1, 0, 0);
    applyStimulus("br400",    0, 1, 1, 32'h400, 0, 0, 32'h400, 1, 0, 0);
    applyStimulus("flushend", 0, 1, 0, 0, 0, 0, 32'h404, 0, 0, 0);
    applyStimulus("br200b",   0, 1, 1, 32'h200, 0, 0, 32'h200, 1, 0, 0);
    applyStimulus("trapwins", 0, 1, 1, 32'h400, 1, 32'h80, 32'h080, 1, 0, 0);
    applyStimulus("seq84",    0, 1, 0, 0, 0, 0, 32'h084, 0, 0, 0);

    // Redirect captured while stalled, applied on release
    applyStimulus("stallcap", 0, 0, 1, 32'h300, 0, 0, 32'h084, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus("stallhold", 0, 0, 0, 0, 0, 0, 32'h084, 0, 0, 0);
    applyStimulus("pendapply", 0, 1, 0, 0, 0, 0, 32'h300, 1, 0, 0);
    applyStimulus("seq304",   0, 1, 0, 0, 0, 0, 32'h304, 0, 0, 0);

    // Later capture overwrites; trap over branch during capture
    applyStimulus("cap500",   0, 0, 1, 32'h500, 0, 0, 32'h304, 0, 0, 0);
    applyStimulus("captrap",  0, 0, 1, 32'h700, 1, 32'h600, 32'h304, 0, 0, 0);
    applyStimulus("cap800",   0, 0, 1, 32'h800, 0, 0, 32'h304, 0, 0, 0);
    applyStimulus("apply800", 0, 1, 0, 0, 0, 0, 32'h800, 1, 0, 0);

    // Fresh redirect supersedes a pending one
    applyStimulus("cap900",   0, 0, 1, 32'h900, 0, 0, 32'h800, 0, 0, 0);
    applyStimulus("freshA00", 0, 1, 1, 32'hA00, 0, 0, 32'hA00, 1, 0, 0);
    applyStimulus("pendgone", 0, 1, 0, 0, 0, 0, 32'hA04, 0, 0, 0);

    // Misaligned pending trap, judged at apply time
    applyStimulus("captrap123", 0, 0, 0, 0, 1, 32'h123, 32'hA04, 0, 0, 0);
    applyStimulus("apply120", 0, 1, 0, 0, 0, 0, 32'h120, 1, 1, 0);

    // Misaligned branch, then PC wrap
    applyStimulus("mis402",   0, 1, 1, 32'h402, 0, 0, 32'h400, 1, 1, 0);
    applyStimulus("seq404",   0, 1, 0, 0, 0, 0, 32'h404, 0, 0, 0);
    applyStimulus("brtop",    0, 1, 1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 1, 0, 0);
    applyStimulus("wrap0",    0, 1, 0, 0, 0, 0, 32'h000, 0, 0, 0);
    applyStimulus("seq4",     0, 1, 0, 0, 0, 0, 32'h004, 0, 0, 0);

    // Reset discards a pending redirect and dominates a live one
    applyStimulus("cap300",   0, 0, 1, 32'h300, 0, 0, 32'h004, 0, 0, 0);
    applyStimulus("rstpend",  1, 0, 0, 0, 0, 0, 32'h100, 0, 0, 0);
    applyStimulus("nopend",   0, 1, 0, 0, 0, 0, 32'h104, 0, 0, 0);
    applyStimulus("seq108b",  0, 1, 0, 0, 0, 0, 32'h108, 0, 0, 0);
    applyStimulus("rstwins",  1, 1, 1, 32'h700, 0, 0, 32'h100, 0, 0, 0);
    applyStimulus("seq104b",  0, 1, 0, 0, 0, 0, 32'h104, 0, 0, 0);

    // BTB training at branch_pc 0x40 -> 0x90, then revisit 0x40
    branch_pc = 32'h40;
    applyStimulus("train",    0, 1, 1, 32'h90, 0, 0, 32'h090, 1, 0, 0);
    branch_pc = BPC_IDLE;
    applyStimulus("br3C",     0, 1, 1, 32'h3C, 0, 0, 32'h03C, 1, 0, 0);
    applyStimulus("at40",     0, 1, 0, 0, 0, 0, 32'h040, 0, 0, BTB_ON);
    applyStimulus("hold40",   0, 0, 0, 0, 0, 0, 32'h040, 0, 0, BTB_ON);
    applyStimulus("predict",  0, 1, 0, 0, 0, 0, BTB_ON ? 32'h090 : 32'h044, 0, 0, 0);
    applyStimulus("after",    0, 1, 0, 0, 0, 0, BTB_ON ? 32'h094 : 32'h048, 0, 0, 0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 5 && sb_queue.size() != 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (sb_queue.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d outstanding entries, want 0", sb_queue.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
